bus_cmd_bridge: RTL and testbench
=================================

Name: bus_cmd_bridge

Overview:
- Upstream master for the four-register bank: converts a byte-stream command protocol (e.g. from a UART receiver) into single-cycle register-bank writes and registered reads.
- Read data is returned as a byte stream.
- Drives the bank's write-enable/address/data inputs and samples its registered read-data output.

Parameters:
- DATAW, 8, register data width; must be a multiple of 8. NBYTES = DATAW/8.
- RD_LAT, 1, cycles between o_addr becoming valid and i_data being valid; 1 matches the bank's registered read mux.

Ports:
- i_clk  input  1  clock, all logic rising-edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_rx_data  input  8  command byte in.
- i_rx_valid  input  1  i_rx_data valid.
- o_rx_ready  output  1  bridge accepts byte; transfer when valid & ready.
- o_tx_data  output  8  response byte out.
- o_tx_valid  output  1  o_tx_data valid.
- i_tx_ready  input  1  sink accepts byte; transfer when valid & ready.
- o_we  output  1  bank write strobe, one-cycle pulse.
- o_addr  output  8  bank address, registered.
- o_data  output  DATAW  bank write data, registered.
- i_data  input  DATAW  bank read data.
- o_err  output  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - o_we, o_tx_valid, o_err, o_addr, o_data, o_tx_data, byte counter all 0.
  - o_rx_ready = 0 during reset.
  - Reset mid-command discards the partial command; no write is issued.
- Protocol opcodes:
  - 0x57 write: opcode, addr, NBYTES data bytes LSB first.
  - 0x52 read: opcode, addr; response is NBYTES bytes, LSB first.
- States: IDLE, ADDR, WDATA, WSTROBE, RWAIT, RSEND.
- o_rx_ready is high only in IDLE, ADDR and WDATA (registered-state decode, not combinational on rx_valid).
- IDLE:
  - Accepted 0x57 -> ADDR (write flag set).
  - Accepted 0x52 -> ADDR (write flag clear).
  - Any other accepted byte: o_err=1 the next cycle, stay IDLE.
- ADDR: accepted byte -> o_addr. Write -> WDATA, counter=0. Read -> RWAIT, wait counter=0.
- WDATA:
  - Accepted byte k is placed in o_data[8k+7:8k].
  - After byte NBYTES-1 -> WSTROBE.
- WSTROBE:
  - o_we=1 for exactly one cycle, with o_addr/o_data stable -> IDLE.
  - Write reaches the bank at the WSTROBE clock edge.
- RWAIT:
  - Count RD_LAT cycles with o_addr stable.
  - Then capture i_data into a shift register, load the low byte into o_tx_data, set o_tx_valid -> RSEND.
- RSEND:
  - o_tx_data/o_tx_valid are held stable while i_tx_ready=0.
  - On handshake, shift the next byte and keep valid.
  - After handshake of byte NBYTES-1: o_tx_valid=0 -> IDLE.
  - i_tx_ready stuck low stalls indefinitely; no input is accepted meanwhile.
- o_addr and o_data hold their last values between commands. o_we is never asserted outside WSTROBE.
- o_err does not change the state and does not block the next byte.
- Back-to-back commands need no idle gap: IDLE is ready the cycle after WSTROBE or after the final tx handshake.
- Minimum write latency, from last data byte accepted to o_we: 1 cycle.
- Minimum read latency, from addr byte accepted to o_tx_valid: RD_LAT+1 cycles.

Test Plan:
- Reset mid-write: send 57 02, assert i_rst, release, send 52 02 -> returns 0x00; o_we never pulsed.
- Write then read, DATAW=8: send 57 01 A5 -> o_we pulses once with addr=01, data=A5. Then send 52 01 -> o_tx_data=A5 with a single tx beat.
- DATAW=32: send 57 03 78 56 34 12 -> o_data=0x12345678 at o_we. Then 52 03 with i_tx_ready toggling 1/0 -> bytes 78,56,34,12, each held stable while not ready.
- Bad opcode: send 33 then 52 00 -> o_err pulses exactly once; the read proceeds normally and returns reg0.
- Throughput: stream 57 00 11 57 01 22 57 02 33 57 03 44 with rx_valid held high, then read all four -> 11,22,33,44. No dropped bytes; o_rx_ready is low only during WSTROBE cycles.
- Backpressure: issue a read with i_tx_ready=0 for 10 cycles -> o_rx_ready stays 0 and o_tx_valid stays 1 with constant data.

Source files
------------

// File: rtl/bus_cmd_bridge.sv
// bus_cmd_bridge: turns a byte-stream command protocol into register-bank writes and
// registered reads, returning read data as a byte stream.
module bus_cmd_bridge #(
  parameter int DATAW = 8,
  parameter int RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_we,
  output logic [7:0]       o_addr,
  output logic [DATAW-1:0] o_data,
  input  logic [DATAW-1:0] i_data,
  output logic             o_err
);
  localparam int NBYTES = DATAW / 8;
  localparam int CMAX = NBYTES > RD_LAT ? NBYTES : RD_LAT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAST_B = CW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_W = CW'(RD_LAT);
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WSTROBE, RWAIT, RSEND} state_t;
  state_t state, state_d;
  logic wr, rx_hs, tx_hs, op_ok;
  logic [CW-1:0] cnt;
  logic [DATAW-1:0] sh;
  assign rx_hs = i_rx_valid && o_rx_ready;
  assign tx_hs = o_tx_valid && i_tx_ready;
  assign op_ok = i_rx_data == OP_WR || i_rx_data == OP_RD;
  assign o_rx_ready = !i_rst && (state == IDLE || state == ADDR || state == WDATA);
  assign o_we = state == WSTROBE;
  assign o_tx_valid = state == RSEND;
  assign o_tx_data = sh[7:0];
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = rx_hs && op_ok ? ADDR : IDLE;
      ADDR:    state_d = rx_hs ? (wr ? WDATA : RWAIT) : ADDR;
      WDATA:   state_d = rx_hs && cnt == LAST_B ? WSTROBE : WDATA;
      WSTROBE: state_d = IDLE;
      RWAIT:   state_d = cnt == LAST_W ? RSEND : RWAIT;
      RSEND:   state_d = tx_hs && cnt == LAST_B ? IDLE : RSEND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_d;
  // cnt is shared: data-byte index in WDATA/RSEND, latency count in RWAIT
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr <= 1'b0;
      cnt <= '0;
      o_addr <= '0;
      o_data <= '0;
      sh <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= state == IDLE && rx_hs && !op_ok;
      if (state == IDLE && rx_hs) wr <= i_rx_data == OP_WR;
      if (state == ADDR && rx_hs) begin
        o_addr <= i_rx_data;
        cnt <= '0;
      end
      if (state == WDATA && rx_hs) begin
        o_data[{cnt, 3'b000} +: 8] <= i_rx_data;
        cnt <= cnt + 1'b1;
      end
      if (state == RWAIT) begin
        cnt <= cnt == LAST_W ? '0 : cnt + 1'b1;
        if (cnt == LAST_W) sh <= i_data;
      end
      if (state == RSEND && tx_hs) begin
        sh <= sh >> 8;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_bus_cmd_bridge.sv
// tb_bus_cmd_bridge: directed tests of 8-bit and 32-bit bridges, each driving a
// four-register bank model with a registered read port.
module tb_bus_cmd_bridge;
  logic clk = 0, rst = 1, sel = 0;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, tx_ready = 0;
  logic rr8, rr32, tv8, tv32, we8, we32, err8, err32;
  logic [7:0] td8, td32, a8, a32, d8;
  logic [31:0] d32;
  logic [7:0] rd8 = '0;
  logic [31:0] rd32 = '0;
  logic [7:0] mem8 [4] = '{default: '0};
  logic [31:0] mem32 [4] = '{default: '0};
  logic [7:0] we_a8 = '0, we_a32 = '0, we_d8 = '0;
  logic [31:0] we_d32 = '0;
  int we_n8 = 0, we_n32 = 0, err_n8 = 0, mon_cyc = 0, mon_stall = 0;
  logic mon = 0;
  int checks = 0, errors = 0;
  logic rx_ready, tx_valid;
  logic [7:0] tx_data;
  assign rx_ready = sel ? rr32 : rr8;
  assign tx_valid = sel ? tv32 : tv8;
  assign tx_data = sel ? td32 : td8;

  always #5 clk = ~clk;

  bus_cmd_bridge #(.DATAW(8), .RD_LAT(1)) u8 (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid && !sel),
    .o_rx_ready(rr8), .o_tx_data(td8), .o_tx_valid(tv8), .i_tx_ready(tx_ready && !sel),
    .o_we(we8), .o_addr(a8), .o_data(d8), .i_data(rd8), .o_err(err8));

  bus_cmd_bridge #(.DATAW(32), .RD_LAT(1)) u32 (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid && sel),
    .o_rx_ready(rr32), .o_tx_data(td32), .o_tx_valid(tv32), .i_tx_ready(tx_ready && sel),
    .o_we(we32), .o_addr(a32), .o_data(d32), .i_data(rd32), .o_err(err32));

  always @(posedge clk) begin
    if (we8) begin
      mem8[a8[1:0]] <= d8;
      we_n8 <= we_n8 + 1;
      we_a8 <= a8;
      we_d8 <= d8;
    end
    if (we32) begin
      mem32[a32[1:0]] <= d32;
      we_n32 <= we_n32 + 1;
      we_a32 <= a32;
      we_d32 <= d32;
    end
    rd8 <= mem8[a8[1:0]];
    rd32 <= mem32[a32[1:0]];
    if (err8) err_n8 <= err_n8 + 1;
    if (mon) begin
      mon_cyc <= mon_cyc + 1;
      if (!rr8) mon_stall <= mon_stall + 1;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h rx_ready=0 required 1", b);
    end
    @(negedge clk);
  endtask

  task automatic recv(input bit stall, output logic [7:0] b, output bit held);
    int n = 0;
    logic [7:0] first;
    held = 1;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      checks++; errors++;
      $display("FAIL recv_timeout tx_valid=0 required 1");
      b = 'x;
      held = 0;
      return;
    end
    first = tx_data;
    if (stall) begin
      @(negedge clk);
      held = tx_valid && tx_data === first;
    end
    tx_ready = 1;
    b = tx_data;
    @(negedge clk);
    tx_ready = 0;
  endtask

  task automatic test_reset;
    logic [7:0] b;
    bit h;
    @(negedge clk);
    checks++;
    if ({rr8, rr32, we8, we32, tv8, tv32, err8, err32} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000000", {rr8, rr32, we8, we32, tv8, tv32, err8, err32});
    end
    checks++;
    if ({a8, d8, td8} !== 24'h0) begin
      errors++; $display("FAIL reset_data8 got=%h exp=000000", {a8, d8, td8});
    end
    checks++;
    if ({a32, d32, td32} !== 48'h0) begin
      errors++; $display("FAIL reset_data32 got=%h exp=0", {a32, d32, td32});
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (rr8 !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got=%b exp=1", rr8);
    end
    sel = 0;
    send(8'h57); send(8'h02);
    rx_valid = 0;
    rst = 1;
    #1;
    checks++;
    if ({rr8, a8} !== 9'h0) begin
      errors++; $display("FAIL reset_midcmd got=%h exp=000", {rr8, a8});
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    send(8'h52); send(8'h02);
    rx_valid = 0;
    recv(0, b, h);
    checks++;
    if (b !== 8'h00) begin
      errors++; $display("FAIL reset_read got=%h exp=00", b);
    end
    checks++;
    if (we_n8 !== 0) begin
      errors++; $display("FAIL reset_no_we got=%0d exp=0", we_n8);
    end
  endtask

  task automatic test_wr_rd8;
    logic [7:0] b;
    bit h;
    int n = 0;
    sel = 0;
    send(8'h57); send(8'h01); send(8'hA5);
    rx_valid = 0;
    checks++;
    if ({we8, a8, d8} !== {1'b1, 8'h01, 8'hA5}) begin
      errors++; $display("FAIL wr8_strobe got=%h exp=101a5", {we8, a8, d8});
    end
    @(negedge clk);
    checks++;
    if ({we8, we_n8, we_a8, we_d8} !== {1'b0, 32'd1, 8'h01, 8'hA5}) begin
      errors++; $display("FAIL wr8_once we=%b n=%0d a=%h d=%h exp we=0 n=1 a=01 d=a5", we8, we_n8, we_a8, we_d8);
    end
    send(8'h52); send(8'h01);
    rx_valid = 0;
    while (!tv8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL rd8_latency got=%0d exp=2", n);
    end
    recv(0, b, h);
    checks++;
    if (b !== 8'hA5) begin
      errors++; $display("FAIL rd8_data got=%h exp=a5", b);
    end
    checks++;
    if (tv8 !== 1'b0) begin
      errors++; $display("FAIL rd8_single_beat tx_valid=%b exp=0", tv8);
    end
  endtask

  task automatic test_wr_rd32;
    logic [7:0] b;
    bit h;
    logic [7:0] exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    sel = 1;
    send(8'h57); send(8'h03); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    rx_valid = 0;
    checks++;
    if ({we32, a32, d32} !== {1'b1, 8'h03, 32'h12345678}) begin
      errors++; $display("FAIL wr32_strobe got=%h exp=10312345678", {we32, a32, d32});
    end
    @(negedge clk);
    checks++;
    if ({we_n32, we_a32, we_d32} !== {32'd1, 8'h03, 32'h12345678}) begin
      errors++; $display("FAIL wr32_once n=%0d a=%h d=%h exp n=1 a=03 d=12345678", we_n32, we_a32, we_d32);
    end
    send(8'h52); send(8'h03);
    rx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      recv(1, b, h);
      checks++;
      if (b !== exp_b[i] || !h) begin
        errors++; $display("FAIL rd32_byte%0d got=%h held=%b exp=%h held=1", i, b, h, exp_b[i]);
      end
    end
    checks++;
    if (tv32 !== 1'b0) begin
      errors++; $display("FAIL rd32_end tx_valid=%b exp=0", tv32);
    end
  endtask

  task automatic test_throughput;
    logic [7:0] b;
    bit h;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel = 0;
    mon = 1;
    for (int i = 0; i < 4; i++) begin
      send(8'h57); send(8'(i)); send(vals[i]);
    end
    rx_valid = 0;
    @(negedge clk);
    mon = 0;
    checks++;
    if (mon_cyc !== 16 || mon_stall !== 4) begin
      errors++; $display("FAIL stream_timing cycles=%0d stalls=%0d exp cycles=16 stalls=4", mon_cyc, mon_stall);
    end
    checks++;
    if (we_n8 !== 5) begin
      errors++; $display("FAIL stream_writes got=%0d exp=5", we_n8);
    end
    for (int i = 0; i < 4; i++) begin
      send(8'h52); send(8'(i));
      rx_valid = 0;
      recv(0, b, h);
      checks++;
      if (b !== vals[i]) begin
        errors++; $display("FAIL stream_read%0d got=%h exp=%h", i, b, vals[i]);
      end
    end
  endtask

  task automatic test_bad_opcode;
    logic [7:0] b;
    bit h;
    int e0;
    sel = 0;
    e0 = err_n8;
    send(8'h33);
    checks++;
    if (err8 !== 1'b1) begin
      errors++; $display("FAIL err_pulse got=%b exp=1", err8);
    end
    send(8'h52); send(8'h00);
    rx_valid = 0;
    recv(0, b, h);
    checks++;
    if (b !== 8'h11) begin
      errors++; $display("FAIL err_then_read got=%h exp=11", b);
    end
    checks++;
    if (err_n8 - e0 !== 1) begin
      errors++; $display("FAIL err_count got=%0d exp=1", err_n8 - e0);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] b;
    bit h;
    int n = 0;
    logic [7:0] exp_b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    sel = 1;
    send(8'h52); send(8'h03);
    rx_data = 8'h57;
    while (!tv32 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rr32 !== 1'b0 || tv32 !== 1'b1 || td32 !== 8'h78) begin
        errors++; $display("FAIL stall%0d rx_ready=%b tx_valid=%b data=%h exp 0 1 78", i, rr32, tv32, td32);
      end
    end
    rx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      recv(0, b, h);
      checks++;
      if (b !== exp_b[i]) begin
        errors++; $display("FAIL drain_byte%0d got=%h exp=%h", i, b, exp_b[i]);
      end
    end
    checks++;
    if ({tv32, rr32} !== 2'b01) begin
      errors++; $display("FAIL drain_idle got=%b exp=01", {tv32, rr32});
    end
  endtask

  initial begin
    test_reset();
    test_wr_rd8();
    test_wr_rd32();
    test_throughput();
    test_bad_opcode();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
